// File: rtl/uart_pkg.sv
// Shared types and timing constants for the UART receive path.
// BIT_PERIOD and FRAME_BITS describe the shift timer's frame timing.
package uart_pkg;

    localparam int BIT_PERIOD = 10;
    localparam int FRAME_BITS = 9;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VERIFY   = 3'd1,
        CLEAR    = 3'd2,
        RECV     = 3'd3,
        STOP_CHK = 3'd4,
        LOAD     = 3'd5,
        FERR     = 3'd6
    } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signals between the receive controller and its neighbours.
// The neighbours are the start detector, shift timer, shift register and rx buffer.
interface uart_rx_ctrl_if #(
    parameter int ERR_W = 8
);
    logic             start_bit_detected;
    logic             serial_in;
    logic             shift_strobe;
    logic             packet_done;
    logic             stop_bit;
    logic             data_ready;
    logic             data_read;
    logic             timer_enable;
    logic             timer_clear;
    logic             load_buffer;
    logic             rx_busy;
    logic             framing_error;
    logic             overrun_error;
    logic [ERR_W-1:0] frame_err_cnt;

    modport master (
        input  start_bit_detected, serial_in, shift_strobe, packet_done,
               stop_bit, data_ready, data_read,
        output timer_enable, timer_clear, load_buffer, rx_busy,
               framing_error, overrun_error, frame_err_cnt
    );

    modport slave (
        output start_bit_detected, serial_in, shift_strobe, packet_done,
               stop_bit, data_ready, data_read,
        input  timer_enable, timer_clear, load_buffer, rx_busy,
               framing_error, overrun_error, frame_err_cnt
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit verification, timer sequencing,
// stop-bit check, buffer load and sticky error reporting.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int HALF_BIT = 5,
    parameter int ERR_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.master bus
);

    localparam int             CNT_W    = $clog2(HALF_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);

    rx_state_t        r_state;
    logic [CNT_W-1:0] r_half;
    logic             r_ferr;
    logic             r_ovr;
    logic [ERR_W-1:0] r_err_cnt;

    // The timer counts its own strobes; the controller only needs packet_done.
    logic w_unused;
    assign w_unused = bus.shift_strobe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_half    <= '0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if ((r_state == LOAD) && bus.data_ready) begin
                r_ovr <= 1'b1;
            end else if (bus.data_read) begin
                r_ovr <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (bus.start_bit_detected) begin
                        r_state <= VERIFY;
                        r_half  <= CNT_W'(1);
                    end
                end
                VERIFY: begin
                    r_half <= r_half + 1'b1;
                    if (r_half == HALF_CNT) begin
                        r_state <= bus.serial_in ? IDLE : CLEAR;
                    end
                end
                CLEAR: begin
                    r_ferr  <= 1'b0;
                    r_state <= RECV;
                end
                RECV: begin
                    if (bus.packet_done) begin
                        r_state <= STOP_CHK;
                    end
                end
                STOP_CHK: begin
                    r_state <= bus.stop_bit ? LOAD : FERR;
                end
                LOAD: begin
                    r_state <= IDLE;
                end
                FERR: begin
                    r_ferr <= 1'b1;
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.timer_enable  = (r_state == RECV);
    assign bus.timer_clear   = (r_state == CLEAR);
    assign bus.load_buffer   = (r_state == LOAD);
    assign bus.rx_busy       = (r_state != IDLE);
    assign bus.framing_error = r_ferr;
    assign bus.overrun_error = r_ovr;
    assign bus.frame_err_cnt = r_err_cnt;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive control unit for the UART receiver. It sequences the shift timer (shift_strobe / packet_done counter pair), start-bit glitch rejection, stop-bit checking, receive-buffer loading and error flagging. It sits between the start-bit detector, the shift timer, the shift register and the rx data buffer.

Parameters:
HALF_BIT, 5, clock cycles from a detected start edge to the start-bit mid-point sample (bit period is 10 cycles).
ERR_W, 8, width of the saturating framing-error counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
start_bit_detected  input  1  one-cycle pulse on a falling edge of the synchronized serial line.
serial_in  input  1  synchronized serial line.
shift_strobe  input  1  timer bit strobe (observed only for bit counting).
packet_done  input  1  timer pulse after 9 strobes (8 data bits and the stop bit).
stop_bit  input  1  stop-bit value held by the shift register.
data_ready  input  1  rx buffer holds unread data.
data_read  input  1  host read pulse.
timer_enable  output  1  enables the shift timer.
timer_clear  output  1  synchronous clear of both timer counters.
load_buffer  output  1  one-cycle pulse that copies shift-register data into the rx buffer.
rx_busy  output  1  high in any state other than IDLE.
framing_error  output  1  sticky framing flag.
overrun_error  output  1  sticky overrun flag.
frame_err_cnt  output  ERR_W  saturating count of framing errors.

Behaviour:
- Reset: state IDLE; all outputs 0; internal half-bit counter 0; frame_err_cnt 0.
- All outputs are Moore outputs decoded from registered state. The exceptions are the error flags and the counter, which are registers.
- States and transitions:
  - IDLE: outputs idle. start_bit_detected=1 -> VERIFY; the half-bit counter loads 1.
  - VERIFY: the counter increments each cycle. When the counter = HALF_BIT, sample serial_in: 0 -> CLEAR; 1 -> IDLE (glitch rejected, no flag change). start_bit_detected is ignored in this state.
  - CLEAR: timer_clear=1 for exactly one cycle; framing_error cleared -> RECV.
  - RECV: timer_enable=1. Stays here until packet_done=1 -> STOP_CHK. shift_strobe does not change state.
  - STOP_CHK: timer_enable=0 (single cycle). stop_bit=1 -> LOAD; stop_bit=0 -> FERR.
  - LOAD: load_buffer=1 for one cycle -> IDLE. If data_ready=1 in this cycle, overrun_error is set on the next edge.
  - FERR: framing_error set; frame_err_cnt increments and saturates at all-ones -> IDLE. No load_buffer pulse.
- Latency:
  - start_bit_detected to timer_clear pulse: HALF_BIT+1 cycles.
  - packet_done to load_buffer: 2 cycles.
- overrun_error:
  - Cleared by data_read=1.
  - If set and clear coincide (LOAD with data_ready=1 and data_read=1 in the same cycle), set wins.
- framing_error:
  - Held through LOAD and IDLE.
  - Cleared only in CLEAR, i.e. when the next valid start bit is accepted.
- frame_err_cnt is never cleared except by reset.
- A start_bit_detected pulse arriving in any state other than IDLE is ignored.
- Reset asserted mid-frame returns to IDLE within the same cycle (asynchronous). timer_enable drops immediately; no load_buffer pulse is generated.
- An illegal state encoding recovers to IDLE.

Decomposition:
- Package uart_pkg holds:
  - enum rx_state_t {IDLE, VERIFY, CLEAR, RECV, STOP_CHK, LOAD, FERR}, 3-bit encoding;
  - localparams BIT_PERIOD=10 and FRAME_BITS=9, shared with the timer.
- No sub-module. The half-bit counter is a small inline register; a flex counter instance is not justified.

Test Plan:
1. Valid frame: start pulse, serial_in held 0 for 10 cycles, then 0x5A, then stop=1 -> timer_clear at +6 cycles, timer_enable high for 90 cycles, load_buffer at packet_done+2, framing_error=0, frame_err_cnt=0.
2. Glitch: start pulse, serial_in returns to 1 after 2 cycles -> sample at cycle 5 reads 1, back to IDLE, timer_enable never asserted, rx_busy low after 6 cycles.
3. Framing error: valid frame with stop_bit=0 -> no load_buffer, framing_error=1, frame_err_cnt=1. Next valid frame clears framing_error in CLEAR and keeps frame_err_cnt=1.
4. Overrun: two valid frames without data_read (data_ready=1 at the second LOAD) -> overrun_error=1. Then data_read pulse -> 0. Repeat with data_read coincident with LOAD -> overrun_error stays 1.
5. Saturation: ERR_W=2, five bad-stop frames -> frame_err_cnt=3.
6. Reset mid-RECV (bit 4): rst pulse -> state IDLE, all outputs 0 immediately. The following frame is received correctly.
